// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB latch, register-file write-data mux, sticky halt and retired-instruction counter
module writeback_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              mem_pend,
    input  logic              flush,
    input  logic              valid_next,
    input  logic              halt_next,
    input  logic              regWr_next,
    input  logic [2:0]        regSel_next,
    input  logic [REG_W-1:0]  regDst_next,
    input  logic [WORD_W-1:0] ALUOut_next,
    input  logic [WORD_W-1:0] dmemload_next,
    input  logic [WORD_W-1:0] nPC_next,
    output logic              WEN,
    output logic [REG_W-1:0]  wsel,
    output logic [WORD_W-1:0] wdat,
    output logic              halt,
    output logic [CNT_W-1:0]  retired
);
    logic              advance, update, valid_q, regwr_q, halt_q;
    logic [2:0]        regsel_q;
    logic [REG_W-1:0]  regdst_q;
    logic [WORD_W-1:0] alu_q, dmem_q, npc_q;
    assign advance = (ihit & ~mem_pend) | (mem_pend & dhit);
    assign update  = advance & ~halt_q;
    // A flushed update loads a bubble with zeroed data fields.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q  <= 1'b0;
            regwr_q  <= 1'b0;
            halt_q   <= 1'b0;
            regsel_q <= '0;
            regdst_q <= '0;
            alu_q    <= '0;
            dmem_q   <= '0;
            npc_q    <= '0;
            retired  <= '0;
        end else if (update) begin
            valid_q  <= valid_next & ~flush;
            regwr_q  <= regWr_next & ~flush;
            halt_q   <= halt_next & valid_next & ~flush;
            regsel_q <= flush ? '0 : regSel_next;
            regdst_q <= flush ? '0 : regDst_next;
            alu_q    <= flush ? '0 : ALUOut_next;
            dmem_q   <= flush ? '0 : dmemload_next;
            npc_q    <= flush ? '0 : nPC_next;
            if (valid_next & ~flush)
                retired <= retired + CNT_W'(1);
        end
    end
    assign wdat = regsel_q == 3'd1 ? dmem_q : regsel_q == 3'd2 ? npc_q : alu_q;
    assign wsel = regdst_q;
    assign WEN  = valid_q & regwr_q & (regdst_q != '0) & ~halt_q;
    assign halt = halt_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed and randomized checks of writeback_stage against a transaction-level model
module tb_writeback_stage;
    localparam int CW = 4;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        ihit = 0, dhit = 0, mem_pend = 0, flush = 0;
    logic        valid_next = 0, halt_next = 0, regWr_next = 0;
    logic [2:0]  regSel_next = 0;
    logic [4:0]  regDst_next = 0;
    logic [31:0] ALUOut_next = 0, dmemload_next = 0, nPC_next = 0;
    logic        WEN, halt;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [CW-1:0] retired;
    int n_checks = 0, n_fail = 0;

    writeback_stage #(.WORD_W(32), .REG_W(5), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_pend(mem_pend), .flush(flush),
        .valid_next(valid_next), .halt_next(halt_next), .regWr_next(regWr_next),
        .regSel_next(regSel_next), .regDst_next(regDst_next), .ALUOut_next(ALUOut_next),
        .dmemload_next(dmemload_next), .nPC_next(nPC_next),
        .WEN(WEN), .wsel(wsel), .wdat(wdat), .halt(halt), .retired(retired)
    );

    always #5 CLK = ~CLK;

    // Model: the instruction currently in write-back, plus halt flag and retire count.
    typedef struct packed {
        logic        valid, wr;
        logic [2:0]  sel;
        logic [4:0]  dst;
        logic [31:0] alu, ld, npc;
    } instr_t;
    instr_t m_wb;
    logic   m_halt;
    int     m_ret;

    function automatic logic [42:0] observed();
        return {WEN, wsel, wdat, halt, retired};
    endfunction

    function automatic logic [42:0] expected();
        logic [31:0] d;
        logic        we;
        d  = m_wb.sel == 1 ? m_wb.ld : m_wb.sel == 2 ? m_wb.npc : m_wb.alu;
        we = m_wb.valid && m_wb.wr && m_wb.dst != 0 && !m_halt;
        return {we, m_wb.dst, d, m_halt, CW'(m_ret % (1 << CW))};
    endfunction

    task automatic model_reset();
        m_wb = '0;
        m_halt = 0;
        m_ret = 0;
    endtask

    task automatic model_edge();
        bit moves;
        moves = mem_pend ? dhit : ihit;
        if (moves && !m_halt) begin
            if (flush) m_wb = '0;
            else begin
                m_wb = '{valid_next, regWr_next, regSel_next, regDst_next, ALUOut_next, dmemload_next, nPC_next};
                if (valid_next) m_ret++;
                if (valid_next && halt_next) m_halt = 1;
            end
        end
    endtask

    task automatic drive(input bit ih, dh, mp, fl, v, h, w, input logic [2:0] s,
                         input logic [4:0] d, input logic [31:0] a, l, n);
        ihit = ih; dhit = dh; mem_pend = mp; flush = fl;
        valid_next = v; halt_next = h; regWr_next = w; regSel_next = s;
        regDst_next = d; ALUOut_next = a; dmemload_next = l; nPC_next = n;
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        RST = 1;
        model_reset();
        @(posedge CLK); #1;
        RST = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (observed() !== 43'd0) begin
            n_fail++; $display("FAIL reset_state got %h want 0", observed());
        end
    endtask

    task automatic test_alu_write();
        drive(1, 0, 0, 0, 1, 0, 1, 0, 8, 32'h1234, 32'h5555, 32'h6666);
        cycle();
        n_checks++;
        if (observed() !== {1'b1, 5'd8, 32'h1234, 1'b0, 4'd1}) begin
            n_fail++; $display("FAIL alu_write got %h want %h", observed(), {1'b1, 5'd8, 32'h1234, 1'b0, 4'd1});
        end
    endtask

    task automatic test_load_stall();
        drive(1, 0, 1, 0, 1, 0, 1, 1, 9, 32'h0, 32'hDEADBEEF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (observed() !== {1'b1, 5'd8, 32'h1234, 1'b0, 4'd1}) begin
                n_fail++; $display("FAIL load_stall_hold%0d got %h want %h", i, observed(), {1'b1, 5'd8, 32'h1234, 1'b0, 4'd1});
            end
        end
        dhit = 1; ihit = 0;
        cycle();
        n_checks++;
        if (observed() !== {1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 4'd2}) begin
            n_fail++; $display("FAIL load_done got %h want %h", observed(), {1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 4'd2});
        end
    endtask

    task automatic test_jal();
        drive(1, 0, 0, 0, 1, 0, 1, 2, 31, 32'h7, 32'h8, 32'h44);
        cycle();
        n_checks++;
        if (observed() !== {1'b1, 5'd31, 32'h44, 1'b0, 4'd3}) begin
            n_fail++; $display("FAIL jal_link got %h want %h", observed(), {1'b1, 5'd31, 32'h44, 1'b0, 4'd3});
        end
        regDst_next = 0;
        cycle();
        n_checks++;
        if (observed() !== {1'b0, 5'd0, 32'h44, 1'b0, 4'd4}) begin
            n_fail++; $display("FAIL jal_r0 got %h want %h", observed(), {1'b0, 5'd0, 32'h44, 1'b0, 4'd4});
        end
    endtask

    task automatic test_flush();
        drive(1, 0, 0, 0, 1, 0, 1, 0, 3, 32'hABCD, 0, 0);
        cycle();
        drive(1, 0, 0, 1, 1, 0, 1, 0, 4, 32'h9999, 0, 0);
        cycle();
        n_checks++;
        if (observed() !== {1'b0, 5'd0, 32'h0, 1'b0, 4'd5}) begin
            n_fail++; $display("FAIL flush_bubble got %h want %h", observed(), {1'b0, 5'd0, 32'h0, 1'b0, 4'd5});
        end
        drive(1, 0, 0, 0, 1, 0, 1, 0, 6, 32'h77, 0, 0);
        cycle();
        drive(1, 0, 1, 1, 1, 0, 1, 0, 7, 32'h88, 0, 0);
        cycle();
        n_checks++;
        if (observed() !== {1'b1, 5'd6, 32'h77, 1'b0, 4'd6}) begin
            n_fail++; $display("FAIL flush_no_advance got %h want %h", observed(), {1'b1, 5'd6, 32'h77, 1'b0, 4'd6});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) cycle();
        n_checks++;
        if (retired !== 4'hF) begin
            n_fail++; $display("FAIL wrap_full got %h want f", retired);
        end
        cycle();
        n_checks++;
        if (retired !== 4'h0) begin
            n_fail++; $display("FAIL wrap_zero got %h want 0", retired);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0, 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
            cycle();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL random%0d got %h want %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 1, 0, 1, 1, 12, 32'h1, 32'hCAFE, 32'h2);
        cycle();
        @(negedge CLK);
        RST = 1;
        #1;
        model_reset();
        n_checks++;
        if (observed() !== 43'd0) begin
            n_fail++; $display("FAIL async_reset got %h want 0", observed());
        end
        @(posedge CLK); #1;
        RST = 0;
    endtask

    task automatic test_halt();
        do_reset();
        drive(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        n_checks++;
        if (halt !== 1'b0 || retired !== 4'd0) begin
            n_fail++; $display("FAIL halt_flush got halt=%b ret=%0d want halt=0 ret=0", halt, retired);
        end
        drive(1, 0, 0, 0, 1, 0, 1, 0, 2, 32'h22, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        n_checks++;
        if (observed() !== {1'b0, 5'd0, 32'h0, 1'b1, 4'd2}) begin
            n_fail++; $display("FAIL halt_set got %h want %h", observed(), {1'b0, 5'd0, 32'h0, 1'b1, 4'd2});
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, i % 2, 0, 1, 0, 1, 0, 5'(i + 1), $urandom, 0, 0);
            cycle();
            n_checks++;
            if (observed() !== {1'b0, 5'd0, 32'h0, 1'b1, 4'd2}) begin
                n_fail++; $display("FAIL halt_frozen%0d got %h want %h", i, observed(), {1'b0, 5'd0, 32'h0, 1'b1, 4'd2});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_write();
        test_load_stall();
        test_jal();
        test_flush();
        test_wrap();
        test_random();
        test_async_reset();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the five-stage pipeline. It holds the MEM/WB pipeline latch, fed by the memory stage's `*_next` outputs. It selects the register-file write data (ALU result, load data or link PC) and drives the register-file write port. The same write port doubles as the forwarding source for execute. It also latches halt, making it sticky for the system, and counts retired instructions.

## Interface
Parameters:
- `WORD_W`, 32, datapath width
- `REG_W`, 5, register index width
- `CNT_W`, 32, retire counter width

Ports:
- `CLK`  in  1  system clock, rising-edge
- `RST`  in  1  asynchronous, active-high reset
- `ihit`  in  1  instruction cache hit (pipeline advance qualifier)
- `dhit`  in  1  data cache hit
- `mem_pend`  in  1  memory stage currently holds a load/store (`dmemREN|dmemWEN`)
- `flush`  in  1  insert bubble into latch on next advance
- `valid_next`  in  1  memory stage holds a real instruction (not a bubble)
- `halt_next`  in  1  memory stage holds HALT
- `regWr_next`  in  1  instruction writes a register
- `regSel_next`  in  3  write-data source select
- `regDst_next`  in  REG_W  destination register
- `ALUOut_next`  in  WORD_W  ALU result
- `dmemload_next`  in  WORD_W  load data
- `nPC_next`  in  WORD_W  PC+4 (link value)
- `WEN`  out  1  register-file write enable
- `wsel`  out  REG_W  register-file write index
- `wdat`  out  WORD_W  register-file write data
- `halt`  out  1  sticky halt to system
- `retired`  out  CNT_W  retired instruction count

## Operation
- `advance = (ihit & ~mem_pend) | (mem_pend & dhit)`. Latch updates only on `advance & ~halt`.
- On update with `flush=1`, the latch loads a bubble: `valid_q=0`, `regWr_q=0`, `halt_q=0`. The data fields are don't-care and are held at 0.
- On update with `flush=0`, the latch loads all `*_next` fields.
- No update means the latch holds its value (stall).
- regSel decode:
  - 0 → `ALUOut_q`
  - 1 → `dmemload_q`
  - 2 → `nPC_q`
  - 3–7 → `ALUOut_q` (reserved)
- `WEN = valid_q & regWr_q & (regDst_q != 0) & ~halt`. This holds even while stalled, because the register-file rewrite is idempotent.
- `wsel = regDst_q`.
- `wdat` is the regSel mux output, combinational from the latch.
- Halt: `halt` sets when the latch loads `halt_next=1` with `valid_next=1` and `flush=0`. It stays 1 until `RST`. While it is 1, the latch, the counter and `WEN` are frozen or forced to 0.
- `retired` increments by 1 on each latch update that loads `valid_next=1` with `flush=0`, HALT included. It wraps modulo 2^CNT_W.

## Timing
- `RST` asserted (any time, asynchronous) forces all of the following immediately:
  - latch: `valid_q=0`, `regWr_q=0`, `halt_q=0`, all data 0
  - outputs: `WEN=0`, `wsel=0`, `wdat=0`, `halt=0`, `retired=0`
- Deassertion takes effect at the first `CLK` edge after release.
- Latency: 1 cycle. Inputs sampled at edge N appear on `WEN`/`wsel`/`wdat` after edge N, within the same cycle, for a negedge register-file write.
- Stall: while `advance=0`, the outputs are stable for any number of cycles.
- `mem_pend=1` with `ihit=1` but `dhit=0` means no advance. `dhit` alone advances, with `ihit` ignored.
- `flush` and `advance` in the same cycle: the bubble wins. `flush` without `advance` has no effect, so the bubble is not inserted.
- HALT and `flush` in the same update: the flush wins and `halt` stays 0.
- A write to `$0` yields `WEN=0` but still counts as retired.
- `retired` at all-ones plus one retire gives 0.

## Test plan
1. Reset: assert `RST` mid-cycle with the latch full → `WEN=0`, `wdat=0`, `halt=0`, `retired=0` immediately, before the next edge.
2. ALU write: `ihit=1`, `mem_pend=0`, `valid_next=1`, `regWr=1`, `regSel=0`, `regDst=8`, `ALUOut=0x1234` → next cycle `WEN=1`, `wsel=8`, `wdat=0x1234`, `retired=1`.
3. Load stall: `mem_pend=1`, `ihit=1`, `dhit=0` for 3 cycles, then `dhit=1` with `regSel=1`, `dmemload=0xDEADBEEF`, `regDst=9` → outputs hold the old value for 3 cycles, then show `wsel=9`, `wdat=0xDEADBEEF`.
4. JAL: `regSel=2`, `nPC=0x00000044`, `regDst=31` → `wdat=0x44`, `wsel=31`. With `regDst=0` and `regWr=1` → `WEN=0`, `retired` still increments.
5. Flush: `flush=1` with `advance=1`, `valid_next=1`, `regWr=1` → `WEN=0`, `retired` unchanged. Then `flush=1` with `advance=0` → latch unchanged.
6. Halt: HALT loaded → `halt=1` and stays 1 for 10 further cycles of valid `regWr` traffic, with `WEN=0` and `retired` frozen. HALT together with `flush=1` → `halt=0`.
